// File: rtl/udp_tx_status_reporter.sv
// rtl/udp_tx_status_reporter.sv - UDP status datagram source: snapshots sw and emits one 4-byte payload per trigger
//
// Purpose: on each trigger, capture the 4-bit switch bank and present one UDP header
// (constant addressing fields) followed by a 4-byte payload stream.
// Payload: 8'h5A, seq[7:0], {4'h0, sw}, xor of the first three bytes.
//
// Ports:
//   udp_sys_clk, system_reset_n        clock, asynchronous active-low reset
//   sw[3:0], send_req                  status bits and rising-edge trigger
//   udp_hdr_valid / udp_hdr_ready      header handshake
//   udp_ip_source_ip .. udp_checksum   constant header fields
//   tdata/tvalid/tready/tlast          payload stream; tkeep=1, tuser=0
//   busy, pkt_count                    packet in flight, datagrams completed
//
// Optional feature: define UDP_TX_PERIODIC_EN to add a free-running timer that
// triggers every PERIOD_CYCLES cycles (PERIOD_CYCLES=0 keeps the timer off).

module udp_tx_status_reporter #(
    parameter logic [31:0] SRC_IP        = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [31:0] DST_IP        = {8'd192, 8'd168, 8'd1, 8'd127},
    parameter logic [15:0] SRC_PORT      = 16'd3001,
    parameter logic [15:0] DST_PORT      = 16'd3000,
    parameter logic [7:0]  TTL           = 8'd64,
    parameter logic [31:0] PERIOD_CYCLES = 32'd125_000_000
) (
    input  logic        udp_sys_clk,
    input  logic        system_reset_n,
    input  logic [3:0]  sw,
    input  logic        send_req,
    output logic        udp_hdr_valid,
    input  logic        udp_hdr_ready,
    output logic [31:0] udp_ip_source_ip,
    output logic [31:0] udp_ip_dest_ip,
    output logic [15:0] udp_source_port,
    output logic [15:0] udp_dest_port,
    output logic [15:0] udp_length,
    output logic [7:0]  udp_ip_ttl,
    output logic [5:0]  udp_ip_dscp,
    output logic [1:0]  udp_ip_ecn,
    output logic [15:0] udp_checksum,
    output logic [7:0]  tdata,
    output logic        tvalid,
    output logic        tlast,
    input  logic        tready,
    output logic        tkeep,
    output logic        tuser,
    output logic        busy,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    state_t      state, state_d;
    logic        send_req_q, send_req_q_d;
    logic        pending, pending_d;
    logic [7:0]  seq, seq_d;
    logic [3:0]  sw_q, sw_q_d;
    logic [1:0]  idx, idx_d;
    logic        hdr_valid_r, hdr_valid_d;
    logic        tvalid_r, tvalid_d;
    logic        tlast_r, tlast_d;
    logic [7:0]  tdata_r, tdata_d;
    logic        busy_r, busy_d;
    logic [15:0] pkt_count_r, pkt_count_d;
    logic        timer_tick;
    logic        trigger;
    logic [1:0]  idx_nxt;

    // Payload bytes are derived from seq and sw_q, both frozen for the whole packet,
    // so a byte stays stable for as long as the sink applies backpressure.
    function automatic logic [7:0] pay_byte(input logic [1:0] i, input logic [7:0] s,
                                            input logic [3:0] w);
        logic [7:0] b0, b1, b2;
        b0 = 8'h5A;
        b1 = s;
        b2 = {4'h0, w};
        case (i)
            2'd0:    pay_byte = b0;
            2'd1:    pay_byte = b1;
            2'd2:    pay_byte = b2;
            default: pay_byte = b0 ^ b1 ^ b2;
        endcase
    endfunction

`ifdef UDP_TX_PERIODIC_EN
    logic [31:0] timer;

    assign timer_tick = (PERIOD_CYCLES != 32'd0) && (timer == PERIOD_CYCLES - 32'd1);

    // Free-running: keeps counting while a packet is in flight; a tick during a
    // packet lands in pending like any other trigger.
    always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            timer <= 32'd0;
        end else if (PERIOD_CYCLES == 32'd0 || timer_tick) begin
            timer <= 32'd0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    // No timer: the period is irrelevant and the tick is tied off.
    assign timer_tick = (PERIOD_CYCLES == 32'd0) & 1'b0;
`endif

    // Edge and timer sources OR together, so coincident sources make one trigger.
    assign trigger = (send_req & ~send_req_q) | timer_tick;
    assign idx_nxt = idx + 2'd1;

    always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state       <= S_IDLE;
            send_req_q  <= 1'b0;
            pending     <= 1'b0;
            seq         <= 8'd0;
            sw_q        <= 4'd0;
            idx         <= 2'd0;
            hdr_valid_r <= 1'b0;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tdata_r     <= 8'd0;
            busy_r      <= 1'b0;
            pkt_count_r <= 16'd0;
        end else begin
            state       <= state_d;
            send_req_q  <= send_req_q_d;
            pending     <= pending_d;
            seq         <= seq_d;
            sw_q        <= sw_q_d;
            idx         <= idx_d;
            hdr_valid_r <= hdr_valid_d;
            tvalid_r    <= tvalid_d;
            tlast_r     <= tlast_d;
            tdata_r     <= tdata_d;
            busy_r      <= busy_d;
            pkt_count_r <= pkt_count_d;
        end
    end

    // All outputs are registered next-state values: ready inputs only ever reach
    // valid outputs through a flop.
    always_comb begin
        state_d      = state;
        send_req_q_d = send_req;
        pending_d    = pending;
        seq_d        = seq;
        sw_q_d       = sw_q;
        idx_d        = idx;
        hdr_valid_d  = hdr_valid_r;
        tvalid_d     = tvalid_r;
        tlast_d      = tlast_r;
        tdata_d      = tdata_r;
        busy_d       = busy_r;
        pkt_count_d  = pkt_count_r;

        case (state)
            S_IDLE: begin
                if (trigger || pending) begin
                    sw_q_d      = sw;
                    pending_d   = 1'b0;
                    hdr_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_HDR;
                end
            end
            S_HDR: begin
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (hdr_valid_r && udp_hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    tvalid_d    = 1'b1;
                    idx_d       = 2'd0;
                    tdata_d     = pay_byte(2'd0, seq, sw_q);
                    tlast_d     = 1'b0;
                    state_d     = S_PAY;
                end
            end
            S_PAY: begin
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (tvalid_r && tready) begin
                    if (idx == 2'd3) begin
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        tdata_d     = 8'd0;
                        seq_d       = seq + 8'd1;
                        pkt_count_d = pkt_count_r + 16'd1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d   = idx_nxt;
                        tdata_d = pay_byte(idx_nxt, seq, sw_q);
                        tlast_d = (idx_nxt == 2'd3);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign udp_hdr_valid    = hdr_valid_r;
    assign tvalid           = tvalid_r;
    assign tlast            = tlast_r;
    assign tdata            = tdata_r;
    assign busy             = busy_r;
    assign pkt_count        = pkt_count_r;

    assign udp_ip_source_ip = SRC_IP;
    assign udp_ip_dest_ip   = DST_IP;
    assign udp_source_port  = SRC_PORT;
    assign udp_dest_port    = DST_PORT;
    assign udp_length       = 16'd12;
    assign udp_ip_ttl       = TTL;
    assign udp_ip_dscp      = 6'd0;
    assign udp_ip_ecn       = 2'd0;
    assign udp_checksum     = 16'd0;
    assign tkeep            = 1'b1;
    assign tuser            = 1'b0;

endmodule

// File: tb/tb_udp_tx_status_reporter.sv
// tb/tb_udp_tx_status_reporter.sv - self-checking bench for udp_tx_status_reporter

module tb_udp_tx_status_reporter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sw = 4'h0;
    logic        send_req = 1'b0;
    logic        hdr_ready = 1'b1;
    logic        tready = 1'b1;
    logic        hdr_valid, tvalid, tlast, tkeep, tuser, busy;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port, ulen, csum, pkt_count;
    logic [7:0]  ttl, tdata;
    logic [5:0]  dscp;
    logic [1:0]  ecn;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    udp_tx_status_reporter dut (
        .udp_sys_clk      (clk),
        .system_reset_n   (rst_n),
        .sw               (sw),
        .send_req         (send_req),
        .udp_hdr_valid    (hdr_valid),
        .udp_hdr_ready    (hdr_ready),
        .udp_ip_source_ip (src_ip),
        .udp_ip_dest_ip   (dst_ip),
        .udp_source_port  (src_port),
        .udp_dest_port    (dst_port),
        .udp_length       (ulen),
        .udp_ip_ttl       (ttl),
        .udp_ip_dscp      (dscp),
        .udp_ip_ecn       (ecn),
        .udp_checksum     (csum),
        .tdata            (tdata),
        .tvalid           (tvalid),
        .tlast            (tlast),
        .tready           (tready),
        .tkeep            (tkeep),
        .tuser            (tuser),
        .busy             (busy),
        .pkt_count        (pkt_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: packet lifecycle idle -> header offered -> 4 bytes -> idle,
    // with a one-deep coalescing request latch.
    int         m_phase;
    int         m_i;
    bit         m_pend;
    bit         m_prev;
    logic [7:0] m_seq;
    logic [15:0] m_cnt;
    logic [7:0] m_bytes [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_i = 0; m_pend = 0; m_prev = 0; m_seq = 8'd0; m_cnt = 16'd0;
        end else begin
            bit trig;
            trig   = send_req && !m_prev;
            m_prev = send_req;
            if (m_phase == 0) begin
                if (trig || m_pend) begin
                    m_bytes[0] = 8'h5A;
                    m_bytes[1] = m_seq;
                    m_bytes[2] = {4'h0, sw};
                    m_bytes[3] = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2];
                    m_pend  = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (trig) m_pend = 1;
                if (hdr_ready) begin m_phase = 2; m_i = 0; end
            end else begin
                if (trig) m_pend = 1;
                if (tready) begin
                    if (m_i == 3) begin
                        m_phase = 0; m_seq = m_seq + 8'd1; m_cnt = m_cnt + 16'd1;
                    end else begin
                        m_i = m_i + 1;
                    end
                end
            end
        end
    end

    // Compare process: every cycle out of reset, shortly after the active edge.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("hdr_valid", hdr_valid, (m_phase == 1));
            check("tvalid", tvalid, (m_phase == 2));
            check("busy", busy, (m_phase != 0));
            check("pkt_count", pkt_count, m_cnt);
            if (m_phase == 2) begin
                check("tdata", tdata, m_bytes[m_i]);
                check("tlast", tlast, (m_i == 3));
            end
        end
    end

    // Accepted payload bytes, in order.
    logic [7:0] got [$];
    bit         got_last [$];
    always @(posedge clk) begin
        if (rst_n && tvalid && tready) begin
            got.push_back(tdata);
            got_last.push_back(tlast);
        end
    end

    // Backpressure pattern 1,0,0,1 while enabled.
    bit tr_mode = 0;
    int tr_k = 0;
    always @(negedge clk) begin
        if (tr_mode) begin
            tready = (tr_k == 0 || tr_k == 3);
            tr_k   = (tr_k + 1) % 4;
        end
    end

    task automatic pulse(input bit chk_lat);
        @(negedge clk);
        send_req = 1'b1;
        @(posedge clk);
        #2;
        if (chk_lat) check("hdr_latency", hdr_valid, 1'b1);
        @(negedge clk);
        send_req = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] target);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (pkt_count == target) done = 1;
        end
        check("wait_pkt_count", done, 1'b1);
    endtask

    task automatic check_pkt(input string name, input int off,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] e [4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        if (got.size() < off + 4) begin
            check({name, "_size"}, got.size(), off + 4);
        end else begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s_b%0d", name, k), got[off + k], e[k]);
                check($sformatf("%s_last%0d", name, k), got_last[off + k], (k == 3));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hdr_valid", hdr_valid, 1'b0);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_count", pkt_count, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single packet, sw=A, ready tied high
        sw = 4'hA;
        pulse(1);
        wait_cnt(16'd1);
        check_pkt("pkt0", 0, 8'h5A, 8'h00, 8'h0A, 8'h50);
        check("pkt0_count", pkt_count, 16'd1);

        // Second packet, sw=3, plus constant header fields
        got.delete(); got_last.delete();
        sw = 4'h3;
        pulse(1);
        wait_cnt(16'd2);
        check_pkt("pkt1", 0, 8'h5A, 8'h01, 8'h03, 8'h58);
        check("udp_length", ulen, 16'd12);
        check("dest_ip", dst_ip, 32'hC0A8017F);
        check("dest_port", dst_port, 16'd3000);
        check("src_ip", src_ip, 32'hC0A80180);
        check("src_port", src_port, 16'd3001);
        check("ttl_dscp_ecn_csum", {ttl, dscp, ecn, csum}, {8'd64, 6'd0, 2'd0, 16'd0});
        check("tkeep_tuser", {tkeep, tuser}, 2'b10);

        // Backpressure on payload
        got.delete(); got_last.delete();
        sw = 4'h5;
        tr_k = 0;
        tr_mode = 1;
        pulse(1);
        wait_cnt(16'd3);
        tr_mode = 0;
        tready = 1'b1;
        check("bp_handshakes", got.size(), 4);
        check_pkt("pkt2", 0, 8'h5A, 8'h02, 8'h05, 8'h5D);

        // Header stall with three triggers: one packet plus one coalesced
        got.delete(); got_last.delete();
        hdr_ready = 1'b0;
        sw = 4'h1;
        pulse(1);
        sw = 4'h7;
        repeat (3) @(negedge clk);
        pulse(0);
        repeat (4) @(negedge clk);
        pulse(0);
        repeat (8) @(negedge clk);
        sw = 4'hC;
        hdr_ready = 1'b1;
        wait_cnt(16'd5);
        repeat (10) @(negedge clk);
        check("stall_count", pkt_count, 16'd5);
        check("stall_idle", busy, 1'b0);
        check("stall_bytes", got.size(), 8);
        check_pkt("pkt3", 0, 8'h5A, 8'h03, 8'h01, 8'h58);
        check_pkt("pkt4", 4, 8'h5A, 8'h04, 8'h0C, 8'h52);

        // Reset mid-packet after byte1 accepted
        got.delete(); got_last.delete();
        sw = 4'h9;
        pulse(1);
        begin
            bit seen = 0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge clk);
                if (got.size() >= 2) seen = 1;
            end
            check("mid_byte1_seen", seen, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_hdr_valid", hdr_valid, 1'b0);
        check("mid_rst_tvalid", tvalid, 1'b0);
        check("mid_rst_tlast", tlast, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pkt_count", pkt_count, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        got.delete(); got_last.delete();
        sw = 4'h6;
        pulse(1);
        wait_cnt(16'd1);
        check_pkt("post_rst", 0, 8'h5A, 8'h00, 8'h06, 8'h5C);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
